// File: rtl/toy_rename_recover_ctrl_pkg.sv
// Shared rename-table constants and the recovery sequencer state type.
package toy_rename_recover_ctrl_pkg;

  // Physical register id width used by all rename tables.
  localparam int unsigned PHY_REG_ID_WIDTH = 7;

  // Architectural registers per register class.
  localparam int unsigned DEF_ARCH_REG_NUM = 32;

  // Recovery sequencer states.
  typedef enum logic [1:0] {
    REC_IDLE  = 2'd0,
    REC_DRAIN = 2'd1,
    REC_COPY  = 2'd2,
    REC_LAST  = 2'd3
  } rec_state_e;

endpackage

// File: rtl/toy_rename_recover_ctrl.sv
// Speculative RAT recovery sequencer: after a flush, stalls rename, waits for
// the commit channels to go idle, then copies the committed (backup) rename
// table into the speculative RAT, COPY_WIDTH entries per cycle.
module toy_rename_recover_ctrl
  import toy_rename_recover_ctrl_pkg::*;
#(
  parameter int unsigned ARCH_REG_NUM = DEF_ARCH_REG_NUM,
  parameter int unsigned COPY_WIDTH   = 4,
  parameter int unsigned MODE         = 0,
  localparam int unsigned ARCH_ID_W   = $clog2(ARCH_REG_NUM),
  localparam int unsigned GRP_NUM     = ARCH_REG_NUM / COPY_WIDTH,
  localparam int unsigned GRP_W       = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         flush_req,
  input  logic                                         commit_busy,
  output logic [COPY_WIDTH-1:0][ARCH_ID_W-1:0]         bk_rd_idx,
  input  logic [COPY_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]  bk_rd_phy,
  output logic [COPY_WIDTH-1:0]                        rat_wr_en,
  output logic [COPY_WIDTH-1:0][ARCH_ID_W-1:0]         rat_wr_idx,
  output logic [COPY_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]  rat_wr_phy,
  output logic                                         rename_stall,
  output logic                                         recover_done
);

  rec_state_e            state;
  rec_state_e            state_nxt;
  logic [GRP_W-1:0]      grp_cnt;
  logic [GRP_W-1:0]      grp_nxt;
  logic                  capture;
  logic [COPY_WIDTH-1:0] lane_en;

  // Backup-table read addresses for the current group, plus per-lane write
  // enables (int class never writes arch reg 0).
  always_comb begin
    for (int unsigned i = 0; i < COPY_WIDTH; i++) begin
      bk_rd_idx[i] = ARCH_ID_W'(32'(grp_cnt) * COPY_WIDTH + i);
      lane_en[i]   = (MODE != 0) || (bk_rd_idx[i] != '0);
    end
  end

  // Next-state, group counter and capture decode.
  always_comb begin
    state_nxt = state;
    grp_nxt   = grp_cnt;
    capture   = 1'b0;
    case (state)
      REC_IDLE: begin
        if (flush_req) state_nxt = REC_DRAIN;
      end
      REC_DRAIN: begin
        grp_nxt = '0;
        if (!commit_busy) state_nxt = REC_COPY;
      end
      REC_COPY: begin
        if (flush_req) begin
          state_nxt = REC_DRAIN;
          grp_nxt   = '0;
        end else begin
          capture = 1'b1;
          if (grp_cnt == GRP_W'(GRP_NUM - 1)) begin
            state_nxt = REC_LAST;
            grp_nxt   = '0;
          end else begin
            grp_nxt = grp_cnt + GRP_W'(1);
          end
        end
      end
      REC_LAST: begin
        grp_nxt   = '0;
        state_nxt = flush_req ? REC_DRAIN : REC_IDLE;
      end
      default: begin
        state_nxt = REC_IDLE;
        grp_nxt   = '0;
      end
    endcase
  end

  // State, counter and the single RAT write register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= REC_IDLE;
      grp_cnt    <= '0;
      rat_wr_en  <= '0;
      rat_wr_idx <= '0;
      rat_wr_phy <= '0;
    end else begin
      state     <= state_nxt;
      grp_cnt   <= grp_nxt;
      rat_wr_en <= capture ? lane_en : '0;
      if (capture) begin
        rat_wr_idx <= bk_rd_idx;
        rat_wr_phy <= bk_rd_phy;
      end
    end
  end

  // Stall decoded from registered state; a flush in LAST cancels the done pulse.
  always_comb begin
    rename_stall = (state != REC_IDLE);
    recover_done = (state == REC_LAST) && !flush_req;
  end

endmodule

// File: tb/tb_toy_rename_recover_ctrl.sv
// Bench for toy_rename_recover_ctrl: three instances (int class, fp class,
// eight-wide copy) share stimulus; a group-level recovery model checks every
// cycle, and directed scenarios pin cycle-exact expectations.
module tb_toy_rename_recover_ctrl;
  import toy_rename_recover_ctrl_pkg::*;

  localparam int CW [3] = '{4, 4, 8};
  localparam int GN [3] = '{8, 8, 4};
  localparam int MD [3] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst_n, flush_req, commit_busy;

  logic [3:0][4:0] rd0, rd1, wi0, wi1;
  logic [7:0][4:0] rd2, wi2;
  logic [3:0][6:0] bp0, bp1, wp0, wp1;
  logic [7:0][6:0] bp2, wp2;
  logic [3:0]      en0, en1;
  logic [7:0]      en2;
  logic            st0, st1, st2, dn0, dn1, dn2;

  int bk     [3][32];
  int shadow [3][32];
  int en_a   [3];
  int st_a   [3];
  int dn_a   [3];
  int idx_a  [3][8];
  int phy_a  [3][8];
  int rd_a   [3][8];
  int dcnt   [3];

  int m_act [3];
  int m_drn [3];
  int m_nxt [3];
  int m_pend[3];
  int m_pgrp[3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  toy_rename_recover_ctrl #(.ARCH_REG_NUM(32), .COPY_WIDTH(4), .MODE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .commit_busy(commit_busy),
    .bk_rd_idx(rd0), .bk_rd_phy(bp0), .rat_wr_en(en0), .rat_wr_idx(wi0),
    .rat_wr_phy(wp0), .rename_stall(st0), .recover_done(dn0));

  toy_rename_recover_ctrl #(.ARCH_REG_NUM(32), .COPY_WIDTH(4), .MODE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .commit_busy(commit_busy),
    .bk_rd_idx(rd1), .bk_rd_phy(bp1), .rat_wr_en(en1), .rat_wr_idx(wi1),
    .rat_wr_phy(wp1), .rename_stall(st1), .recover_done(dn1));

  toy_rename_recover_ctrl #(.ARCH_REG_NUM(32), .COPY_WIDTH(8), .MODE(0)) d2 (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .commit_busy(commit_busy),
    .bk_rd_idx(rd2), .bk_rd_phy(bp2), .rat_wr_en(en2), .rat_wr_idx(wi2),
    .rat_wr_phy(wp2), .rename_stall(st2), .recover_done(dn2));

  // Backup table read ports, same-cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bp0[i] = 7'(bk[0][rd0[i]]);
      bp1[i] = 7'(bk[1][rd1[i]]);
    end
    for (int i = 0; i < 8; i++) bp2[i] = 7'(bk[2][rd2[i]]);
  end

  // Flatten the three instances into common arrays.
  always_comb begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) begin
        idx_a[k][i] = 0; phy_a[k][i] = 0; rd_a[k][i] = 0;
      end
    for (int i = 0; i < 4; i++) begin
      idx_a[0][i] = int'(wi0[i]); phy_a[0][i] = int'(wp0[i]); rd_a[0][i] = int'(rd0[i]);
      idx_a[1][i] = int'(wi1[i]); phy_a[1][i] = int'(wp1[i]); rd_a[1][i] = int'(rd1[i]);
    end
    for (int i = 0; i < 8; i++) begin
      idx_a[2][i] = int'(wi2[i]); phy_a[2][i] = int'(wp2[i]); rd_a[2][i] = int'(rd2[i]);
    end
    en_a[0] = int'(en0); en_a[1] = int'(en1); en_a[2] = int'(en2);
    st_a[0] = int'(st0); st_a[1] = int'(st1); st_a[2] = int'(st2);
    dn_a[0] = int'(dn0); dn_a[1] = int'(dn1); dn_a[2] = int'(dn2);
  end

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0d expected=%0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the group-level model, then advance the model
  // with the inputs the DUT will sample at the coming edge.
  int e_en, lane_arch;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("stall", k, st_a[k], m_act[k]);
      chk("done", k, dn_a[k],
          int'(m_act[k] != 0 && m_drn[k] == 0 && m_nxt[k] == GN[k] && !flush_req));
      e_en = 0;
      for (int i = 0; i < CW[k]; i++) begin
        lane_arch = m_pgrp[k] * CW[k] + i;
        if (m_pend[k] != 0 && !(MD[k] == 0 && lane_arch == 0)) e_en |= (1 << i);
        if (m_pend[k] != 0) begin
          chk("wr_idx", k, idx_a[k][i], lane_arch);
          chk("wr_phy", k, phy_a[k][i], bk[k][lane_arch]);
        end
        if (m_act[k] != 0 && m_drn[k] == 0 && m_nxt[k] < GN[k])
          chk("rd_idx", k, rd_a[k][i], m_nxt[k] * CW[k] + i);
        if (((en_a[k] >> i) & 1) != 0) shadow[k][idx_a[k][i] & 31] = phy_a[k][i];
      end
      chk("wr_en", k, en_a[k], e_en);
      if (dn_a[k] != 0) dcnt[k]++;

      // model advance
      m_pend[k] = 0;
      if (!rst_n) begin
        m_act[k] = 0; m_drn[k] = 0; m_nxt[k] = 0;
      end else if (m_act[k] == 0) begin
        if (flush_req) begin m_act[k] = 1; m_drn[k] = 1; end
      end else if (m_drn[k] != 0) begin
        if (!commit_busy) begin m_drn[k] = 0; m_nxt[k] = 0; end
      end else if (flush_req) begin
        m_drn[k] = 1; m_nxt[k] = 0;
      end else if (m_nxt[k] < GN[k]) begin
        m_pend[k] = 1; m_pgrp[k] = m_nxt[k]; m_nxt[k]++;
      end else begin
        m_act[k] = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic new_tables();
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 32; a++) bk[k][a] = int'($urandom_range(0, 127));
  endtask

  task automatic clear_run();
    for (int k = 0; k < 3; k++) begin
      dcnt[k] = 0;
      for (int a = 0; a < 32; a++) shadow[k][a] = -1;
    end
  endtask

  task automatic rat_check();
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 32; a++)
        chk("rat", k, shadow[k][a], (MD[k] == 0 && a == 0) ? -1 : bk[k][a]);
  endtask

  // Flush at cycle 0 with no commit traffic; cycle-exact literals.
  task automatic run_basic();
    new_tables();
    clear_run();
    flush_req = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      chk("b_stall", 0, st_a[0], int'(c >= 1 && c <= 10));
      chk("b_en", 0, en_a[0], (c == 3) ? 14 : (c >= 4 && c <= 10) ? 15 : 0);
      chk("b_done", 0, dn_a[0], int'(c == 10));
      if (c == 3) chk("b_en_fp", 1, en_a[1], 15);
      chk("b_done", 2, dn_a[2], int'(c == 6));
      chk("b_en", 2, en_a[2], (c == 3) ? 254 : (c >= 4 && c <= 6) ? 255 : 0);
      next_cycle();
      flush_req = 1'b0;
    end
    rat_check();
    for (int k = 0; k < 3; k++) chk("b_done_cnt", k, dcnt[k], 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_act[k] = 0; m_drn[k] = 0; m_nxt[k] = 0; m_pend[k] = 0; m_pgrp[k] = 0;
    end
    rst_n = 1'b0; flush_req = 1'b0; commit_busy = 1'b0;
    new_tables();
    clear_run();
    next_cycle();
    next_cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_stall", k, st_a[k], 0);
      chk("rst_en", k, en_a[k], 0);
      chk("rst_done", k, dn_a[k], 0);
      chk("rst_idx", k, idx_a[k][1], 0);
      chk("rst_phy", k, phy_a[k][1], 0);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    run_basic();

    // Commit traffic for five cycles after the flush delays everything by five.
    new_tables();
    clear_run();
    flush_req = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      chk("d_done", 0, dn_a[0], int'(c == 15));
      if (c <= 7) chk("d_en_drain", 0, en_a[0], 0);
      if (c == 8) chk("d_en_first", 0, en_a[0], 14);
      chk("d_done", 2, dn_a[2], int'(c == 11));
      next_cycle();
      flush_req   = 1'b0;
      commit_busy = (c + 1 >= 1 && c + 1 <= 5);
    end
    commit_busy = 1'b0;
    rat_check();

    // Re-flush while the int instance is reading group 3.
    new_tables();
    clear_run();
    flush_req = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c == 5) begin
        chk("r_trail_en", 0, en_a[0], 15);
        chk("r_trail_idx", 0, idx_a[0][0], 8);
      end
      if (c == 6) chk("r_gap_en", 0, en_a[0], 0);
      chk("r_done", 0, dn_a[0], int'(c == 15));
      chk("r_done", 2, dn_a[2], int'(c == 11));
      next_cycle();
      flush_req = (c + 1 == 5);
    end
    rat_check();
    for (int k = 0; k < 3; k++) chk("r_done_cnt", k, dcnt[k], 1);

    // Reset while the int instance is reading group 5, then a clean recovery.
    new_tables();
    clear_run();
    flush_req = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c == 7) chk("x_stall_pre", 0, st_a[0], 1);
      if (c >= 8) begin
        chk("x_stall", 0, st_a[0], 0);
        chk("x_en", 0, en_a[0], 0);
        chk("x_done", 0, dn_a[0], 0);
      end
      next_cycle();
      flush_req = 1'b0;
      rst_n     = (c + 1 != 7);
    end
    chk("x_done_cnt", 0, dcnt[0], 0);
    chk("x_done_cnt", 1, dcnt[1], 0);
    chk("x_done_cnt", 2, dcnt[2], 1);
    run_basic();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toy_rename_recover_ctrl.md
Name: toy_rename_recover_ctrl

Overview:
- Recovery sequencer for the speculative rename table (RAT) after a pipeline flush.
- Stalls rename and waits for the commit channels to go idle, so the backup (committed) rename table has settled.
- Then walks every architectural register COPY_WIDTH entries per cycle and copies each committed phy id into the speculative RAT.
- Sits in dispatch, between the backup rename regfile entries and the speculative rename table; one instance per register class (int/fp).

Parameters:
- ARCH_REG_NUM, 32: architectural registers per class; must be a multiple of COPY_WIDTH.
- COPY_WIDTH, 4: RAT entries copied per cycle (read ports on backup mux, write ports on RAT).
- MODE, 0: 0 = int class (arch reg 0 never written), 1 = fp class (all entries written).
- Derived: ARCH_ID_W = $clog2(ARCH_REG_NUM); GRP_NUM = ARCH_REG_NUM/COPY_WIDTH; GRP_W = max(1,$clog2(GRP_NUM)).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- flush_req  in  1  single-cycle flush/redirect pulse requesting recovery
- commit_busy  in  1  any v_commit_en bit set this cycle
- bk_rd_idx  out  COPY_WIDTH x ARCH_ID_W  arch ids selected from backup table (combinational from state/counter)
- bk_rd_phy  in  COPY_WIDTH x PHY_REG_ID_WIDTH  backup phy ids for bk_rd_idx, same cycle
- rat_wr_en  out  COPY_WIDTH  RAT write enables (registered)
- rat_wr_idx  out  COPY_WIDTH x ARCH_ID_W  RAT write arch ids (registered)
- rat_wr_phy  out  COPY_WIDTH x PHY_REG_ID_WIDTH  RAT write phy ids (registered)
- rename_stall  out  1  rename must not allocate or write the RAT
- recover_done  out  1  one-cycle pulse: recovery complete

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low; all state changes happen on posedge clk.
- Reset: state = IDLE, grp_cnt = 0, write stage cleared. rat_wr_en = 0, rat_wr_idx/phy = 0, recover_done = 0, rename_stall = 0.
- Reset mid-recovery: aborts immediately, with no done pulse and no further writes.
- rename_stall = (state != IDLE), decoded from registered state.
- States:
  - IDLE: flush_req=1 -> DRAIN.
  - DRAIN: commit_busy=0 -> COPY with grp_cnt=0; otherwise hold. flush_req in DRAIN is absorbed (stay DRAIN).
  - COPY: bk_rd_idx[i] = grp_cnt*COPY_WIDTH+i. Capture into write stage: wr_en[i]=1, idx, phy = bk_rd_phy[i]. grp_cnt++. When grp_cnt==GRP_NUM-1 -> LAST.
  - LAST: write stage presents the final group; recover_done=1 this cycle -> IDLE.
- Write stage: one register stage. Data read in COPY cycle k appears on rat_wr_* in cycle k+1. rat_wr_en is 0 in any cycle not following a COPY capture.
- MODE=0: the lane carrying arch id 0 has rat_wr_en forced 0; idx/phy still driven.
- flush_req during COPY or LAST: -> DRAIN, grp_cnt reset to 0, no recover_done. The already-captured write stage still issues next cycle (committed data, harmless). Full walk restarts after drain.
- flush_req in the same cycle as the IDLE transition out of LAST is not possible; LAST always exits to IDLE or DRAIN.
- commit_busy is ignored outside DRAIN.
- Total latency, flush_req to done with immediate drain: 2 + GRP_NUM cycles. Stall is high for GRP_NUM+2 cycles. Each drain cycle adds one.
- Width rule: grp_cnt*COPY_WIDTH+i computed at ARCH_ID_W bits; no wrap is possible given the divisibility constraint.

Decomposition:
- toy_pack:
  - rec_state_e enum {IDLE, DRAIN, COPY, LAST}.
  - PHY_REG_ID_WIDTH and ARCH_REG_NUM constants, already present for the rename tables.
- No sub-module. The backup-table read mux stays in the parent, which owns the entry instances; this block only drives bk_rd_idx.

Test Plan:
- Basic, defaults: flush_req at cycle 0, commit_busy=0 -> rename_stall high cycles 1-10; rat_wr_en=4'hF cycles 3-10 except cycle 3 = 4'hE (arch 0 masked); recover_done only at cycle 10; RAT equals backup table.
- Drain: commit_busy=1 for 5 cycles after flush -> COPY entered one cycle after busy drops; done delayed by exactly 5 cycles; no rat_wr_en during drain.
- Re-flush: second flush_req in COPY at grp_cnt=3 -> one trailing write of group 2, then DRAIN; full 8-group walk restarts; single recover_done at end.
- MODE=1: same as basic -> cycle 3 rat_wr_en=4'hF, arch 0 written with the backup phy id.
- Reset mid-copy: rst_n=0 at grp_cnt=5 -> next cycle rename_stall=0, rat_wr_en=0, no recover_done; a new flush performs a full recovery.
- Parameter sweep: COPY_WIDTH=8, ARCH_REG_NUM=32 -> 4 copy cycles, done 6 cycles after flush.
